// File: rtl/trace_pkg.sv
// Shared types for the writeback trace monitor.
//   trace_state_t  : capture FSM states
//   trace_entry_t  : one trace record {rd, data, pc, seq} as stored in the FIFO
//   HALT_EBREAK    : default instruction word that ends capture (EBREAK)
// The record carries TRACE_XLEN-bit data/pc; the monitor converts its own
// XLEN-wide ports to and from this width.
package trace_pkg;

    localparam int          TRACE_XLEN  = 32;
    localparam logic [31:0] HALT_EBREAK = 32'h00100073;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_DRAIN   = 2'd2,
        ST_DONE    = 2'd3
    } trace_state_t;

    typedef struct packed {
        logic [4:0]            rd;
        logic [TRACE_XLEN-1:0] data;
        logic [TRACE_XLEN-1:0] pc;
        logic [15:0]           seq;
    } trace_entry_t;

    localparam int TRACE_ENTRY_W = $bits(trace_entry_t);

endpackage

// File: rtl/trace_fifo.sv
// Synchronous FIFO holding trace records.
//   clk, resetn  : clock, asynchronous active-low reset (pointers/level only)
//   clear        : synchronous flush, wins over push/pop
//   push/wr_data : write request; accepted when not full, or when full and a
//                  pop is accepted in the same cycle
//   pop/rd_data  : read request (ignored when empty); rd_data shows the head
//                  combinationally so a push is visible the next cycle
//   full, empty, level : occupancy status (level is 0..DEPTH)
module trace_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH),
    localparam int LW    = AW + 1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic [LW-1:0]    level
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [LW-1:0]    level_reg;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (level_reg == LW'(DEPTH));
    assign empty   = (level_reg == '0);
    assign level   = level_reg;
    assign rd_data = mem[rd_ptr_reg];

    // A full FIFO can still accept a write when the head leaves in the same cycle.
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);

    // DEPTH is a power of two, so the pointers wrap on their own.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else if (clear) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            if (push_ok) wr_ptr_reg <= wr_ptr_reg + AW'(1);
            if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   level_reg <= level_reg + LW'(1);
                2'b01:   level_reg <= level_reg - LW'(1);
                default: level_reg <= level_reg;
            endcase
        end
    end

    // Storage has no reset; pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (push_ok && !clear) mem[wr_ptr_reg] <= wr_data;
    end

endmodule

// File: rtl/wb_trace_monitor.sv
// Register-writeback trace monitor.
// Captures filtered writeback events into a FIFO while armed, stops on the
// halt instruction, then drains and reports done.
//   clk, resetn                 : clock, asynchronous active-low reset
//   enable, clear               : arm capture; synchronous flush to IDLE
//   wb_valid/wb_rd/wb_data/wb_pc: writeback event
//   instr_valid, instr          : decoded instruction (halt detection)
//   rd_mask                     : per-register trace enable
//   out_valid/out_ready/out_*   : trace readout (valid/ready)
//   halted, done, overflow, drop_count, level : status
module wb_trace_monitor
    import trace_pkg::*;
#(
    parameter  int          XLEN      = TRACE_XLEN,
    parameter  int          DEPTH     = 16,
    parameter  logic [31:0] HALT_INSN = HALT_EBREAK,
    localparam int          LW        = $clog2(DEPTH) + 1
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            enable,
    input  logic            clear,
    input  logic            wb_valid,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    input  logic [XLEN-1:0] wb_pc,
    input  logic            instr_valid,
    input  logic [31:0]     instr,
    input  logic [31:0]     rd_mask,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [4:0]      out_rd,
    output logic [XLEN-1:0] out_data,
    output logic [XLEN-1:0] out_pc,
    output logic [15:0]     out_seq,
    output logic            halted,
    output logic            done,
    output logic            overflow,
    output logic [15:0]     drop_count,
    output logic [LW-1:0]   level
);

    trace_state_t state_reg, state_next;
    logic [15:0]  seq_reg;
    logic [15:0]  drop_count_reg;
    logic         overflow_reg;
    logic         fifo_full, fifo_empty;
    logic         qualify, pop_fire, drop;
    logic         halt_seen;
    trace_entry_t push_entry, head_entry;

    assign halt_seen = instr_valid && (instr == HALT_INSN);
    assign qualify   = (state_reg == ST_CAPTURE) && wb_valid &&
                       (wb_rd != 5'd0) && rd_mask[wb_rd];
    assign pop_fire  = out_ready && !fifo_empty;
    // Only a full FIFO with no simultaneous pop loses the event.
    assign drop      = qualify && fifo_full && !pop_fire;

    always_comb begin
        push_entry      = '0;
        push_entry.rd   = wb_rd;
        push_entry.data = TRACE_XLEN'(wb_data);
        push_entry.pc   = TRACE_XLEN'(wb_pc);
        push_entry.seq  = seq_reg;
    end

    trace_fifo #(
        .WIDTH (TRACE_ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .resetn  (resetn),
        .clear   (clear),
        .push    (qualify),
        .wr_data (push_entry),
        .pop     (out_ready),
        .rd_data (head_entry),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (level)
    );

    assign out_valid  = !fifo_empty;
    assign out_rd     = head_entry.rd;
    assign out_data   = XLEN'(head_entry.data);
    assign out_pc     = XLEN'(head_entry.pc);
    assign out_seq    = head_entry.seq;
    assign halted     = (state_reg == ST_DRAIN) || (state_reg == ST_DONE);
    assign done       = (state_reg == ST_DONE);
    assign overflow   = overflow_reg;
    assign drop_count = drop_count_reg;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg      <= ST_IDLE;
            seq_reg        <= '0;
            drop_count_reg <= '0;
            overflow_reg   <= 1'b0;
        end else if (clear) begin
            state_reg      <= ST_IDLE;
            seq_reg        <= '0;
            drop_count_reg <= '0;
            overflow_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            // Dropped events still consume a sequence number so gaps reveal loss.
            if (qualify) seq_reg <= seq_reg + 16'd1;
            if (drop) begin
                overflow_reg <= 1'b1;
                if (drop_count_reg != 16'hFFFF) drop_count_reg <= drop_count_reg + 16'd1;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:    if (enable) state_next = ST_CAPTURE;
            ST_CAPTURE: begin
                if (halt_seen)    state_next = ST_DRAIN;
                else if (!enable) state_next = ST_IDLE;
            end
            ST_DRAIN:   if (fifo_empty) state_next = ST_DONE;
            ST_DONE:    state_next = ST_DONE;
            default:    state_next = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_wb_trace_monitor.sv
module tb_wb_trace_monitor;

    localparam int XLEN  = 32;
    localparam int DEPTH = 4;
    localparam int LW    = $clog2(DEPTH) + 1;
    localparam logic [31:0] HALT = 32'h00100073;

    logic            clk = 1'b0;
    logic            resetn;
    logic            enable, clear;
    logic            wb_valid;
    logic [4:0]      wb_rd;
    logic [XLEN-1:0] wb_data, wb_pc;
    logic            instr_valid;
    logic [31:0]     instr;
    logic [31:0]     rd_mask;
    logic            out_valid, out_ready;
    logic [4:0]      out_rd;
    logic [XLEN-1:0] out_data, out_pc;
    logic [15:0]     out_seq;
    logic            halted, done, overflow;
    logic [15:0]     drop_count;
    logic [LW-1:0]   level;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    wb_trace_monitor #(.XLEN(XLEN), .DEPTH(DEPTH), .HALT_INSN(HALT)) dut (
        .clk(clk), .resetn(resetn), .enable(enable), .clear(clear),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .wb_pc(wb_pc),
        .instr_valid(instr_valid), .instr(instr), .rd_mask(rd_mask),
        .out_valid(out_valid), .out_ready(out_ready), .out_rd(out_rd),
        .out_data(out_data), .out_pc(out_pc), .out_seq(out_seq),
        .halted(halted), .done(done), .overflow(overflow),
        .drop_count(drop_count), .level(level)
    );

    // Advance one cycle; inputs are changed and outputs sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_wb(input logic v, input logic [4:0] rd, input logic [31:0] d, input logic [31:0] pc);
        wb_valid = v; wb_rd = rd; wb_data = d; wb_pc = pc;
    endtask

    // Flush to IDLE, then arm capture so the next step lands in CAPTURE.
    task automatic restart();
        set_wb(0, 0, 0, 0);
        instr_valid = 0; enable = 0; out_ready = 0; rd_mask = 32'hFFFF_FFFF;
        clear = 1; step(); clear = 0;
        enable = 1; step();
    endtask

    task automatic test_reset();
        resetn = 0; enable = 0; clear = 0; out_ready = 0; rd_mask = '1;
        instr_valid = 0; instr = 0; set_wb(0, 0, 0, 0);
        step(); step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        checks++; if (level !== '0) begin errors++; $display("FAIL reset_level: got %0d want 0", level); end
        checks++; if ({halted, done, overflow} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b want 000", {halted, done, overflow}); end
        checks++; if (drop_count !== 16'd0) begin errors++; $display("FAIL reset_drop_count: got %0d want 0", drop_count); end
        resetn = 1; step();
        $display("test_reset done");
    endtask

    task automatic test_basic();
        restart();
        out_ready = 1;
        set_wb(1, 5, 32'h11, 32'h0);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_pre_valid: got %b want 0", out_valid); end
        step();
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid0: got %b want 1", out_valid); end
        checks++; if ({out_rd, out_data, out_pc, out_seq} !== {5'd5, 32'h11, 32'h0, 16'd0})
            begin errors++; $display("FAIL basic_entry0: got rd=%0d data=%0h pc=%0h seq=%0d want 5/11/0/0", out_rd, out_data, out_pc, out_seq); end
        $display("pop rd=%0d data=%0h seq=%0d", out_rd, out_data, out_seq);
        set_wb(1, 6, 32'h22, 32'h4);
        step();
        checks++; if ({out_valid, out_rd, out_data, out_pc, out_seq} !== {1'b1, 5'd6, 32'h22, 32'h4, 16'd1})
            begin errors++; $display("FAIL basic_entry1: got v=%b rd=%0d data=%0h pc=%0h seq=%0d want 1/6/22/4/1", out_valid, out_rd, out_data, out_pc, out_seq); end
        $display("pop rd=%0d data=%0h seq=%0d", out_rd, out_data, out_seq);
        set_wb(0, 0, 0, 0);
        step();
        checks++; if (level !== 0 || out_valid !== 1'b0) begin errors++; $display("FAIL basic_empty: got level=%0d v=%b want 0/0", level, out_valid); end
    endtask

    task automatic test_filter();
        restart();
        rd_mask = 32'hFFFF_FF7F;
        set_wb(1, 0, 32'hAA, 32'h10); step();
        set_wb(1, 7, 32'hBB, 32'h14); step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL filter_none: got %b want 0", out_valid); end
        set_wb(1, 8, 32'hCC, 32'h18); step();
        set_wb(0, 0, 0, 0);
        checks++; if ({out_valid, out_rd, out_seq} !== {1'b1, 5'd8, 16'd0})
            begin errors++; $display("FAIL filter_x8: got v=%b rd=%0d seq=%0d want 1/8/0", out_valid, out_rd, out_seq); end
        $display("pop rd=%0d seq=%0d", out_rd, out_seq);
        out_ready = 1; step(); out_ready = 0;
    endtask

    task automatic test_overflow();
        restart();
        for (int i = 1; i <= 6; i++) begin
            set_wb(1, 5'(i), 32'(i), 32'(4 * i)); step();
        end
        set_wb(0, 0, 0, 0);
        checks++; if (level !== LW'(4)) begin errors++; $display("FAIL ovf_level: got %0d want 4", level); end
        checks++; if (drop_count !== 16'd2) begin errors++; $display("FAIL ovf_drop_count: got %0d want 2", drop_count); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b want 1", overflow); end
        step();
        checks++; if ({out_rd, out_seq} !== {5'd1, 16'd0}) begin errors++; $display("FAIL ovf_stall_hold: got rd=%0d seq=%0d want 1/0", out_rd, out_seq); end
        out_ready = 1;
        for (int k = 0; k < 4; k++) begin
            checks++; if ({out_valid, out_rd, out_seq} !== {1'b1, 5'(k + 1), 16'(k)})
                begin errors++; $display("FAIL ovf_drain%0d: got v=%b rd=%0d seq=%0d want 1/%0d/%0d", k, out_valid, out_rd, out_seq, k + 1, k); end
            $display("pop rd=%0d seq=%0d", out_rd, out_seq);
            step();
        end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ovf_drained: got %b want 0", out_valid); end
        out_ready = 0;
        set_wb(1, 10, 32'h10, 32'h40); step(); set_wb(0, 0, 0, 0);
        checks++; if (out_seq !== 16'd6) begin errors++; $display("FAIL ovf_next_seq: got %0d want 6", out_seq); end
    endtask

    task automatic test_full_push_pop();
        restart();
        for (int i = 1; i <= 4; i++) begin
            set_wb(1, 5'(i), 32'(i), 32'(4 * i)); step();
        end
        checks++; if (level !== LW'(4)) begin errors++; $display("FAIL fpp_full: got %0d want 4", level); end
        out_ready = 1;
        set_wb(1, 11, 32'hAB, 32'h2C); step(); set_wb(0, 0, 0, 0);
        checks++; if (level !== LW'(4)) begin errors++; $display("FAIL fpp_level: got %0d want 4", level); end
        checks++; if ({overflow, drop_count} !== {1'b0, 16'd0}) begin errors++; $display("FAIL fpp_no_drop: got ovf=%b drops=%0d want 0/0", overflow, drop_count); end
        checks++; if (out_seq !== 16'd1) begin errors++; $display("FAIL fpp_head: got %0d want 1", out_seq); end
        step(); step(); step();
        checks++; if ({out_rd, out_data, out_seq} !== {5'd11, 32'hAB, 16'd4})
            begin errors++; $display("FAIL fpp_tail: got rd=%0d data=%0h seq=%0d want 11/ab/4", out_rd, out_data, out_seq); end
        $display("pop rd=%0d seq=%0d", out_rd, out_seq);
        step();
    endtask

    task automatic test_halt();
        int n;
        restart();
        set_wb(1, 3, 32'h33, 32'h0); step();
        set_wb(1, 9, 32'h99, 32'h4); instr_valid = 1; instr = HALT; step();
        instr_valid = 0;
        checks++; if ({halted, done, level} !== {1'b1, 1'b0, LW'(2)})
            begin errors++; $display("FAIL halt_enter: got halted=%b done=%b level=%0d want 1/0/2", halted, done, level); end
        set_wb(1, 4, 32'h44, 32'h8); step(); set_wb(0, 0, 0, 0);
        checks++; if (level !== LW'(2)) begin errors++; $display("FAIL halt_ignore: got %0d want 2", level); end
        out_ready = 1; step();
        checks++; if ({out_rd, out_data, out_seq} !== {5'd9, 32'h99, 16'd1})
            begin errors++; $display("FAIL halt_x9: got rd=%0d data=%0h seq=%0d want 9/99/1", out_rd, out_data, out_seq); end
        $display("pop rd=%0d seq=%0d", out_rd, out_seq);
        step();
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL halt_done_early: got %b want 0", done); end
        n = 0;
        while (!done && n < 10) begin step(); n++; end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL halt_done: got %b want 1 (timeout)", done); end
        enable = 0; step();
        checks++; if ({halted, done} !== 2'b11) begin errors++; $display("FAIL halt_done_hold: got %b want 11", {halted, done}); end
    endtask

    task automatic test_clear();
        restart();
        set_wb(1, 1, 32'h1, 32'h0); step();
        set_wb(1, 2, 32'h2, 32'h4); step();
        set_wb(1, 3, 32'h3, 32'h8); instr_valid = 1; instr = HALT; step();
        instr_valid = 0; set_wb(0, 0, 0, 0);
        checks++; if ({halted, level} !== {1'b1, LW'(3)}) begin errors++; $display("FAIL clr_setup: got halted=%b level=%0d want 1/3", halted, level); end
        clear = 1; step(); clear = 0;
        checks++; if ({out_valid, level, halted, done} !== {1'b0, LW'(0), 1'b0, 1'b0})
            begin errors++; $display("FAIL clr_result: got v=%b level=%0d halted=%b done=%b want 0/0/0/0", out_valid, level, halted, done); end
        enable = 1; step();
        set_wb(1, 5, 32'h55, 32'h0); step(); set_wb(0, 0, 0, 0);
        checks++; if (out_seq !== 16'd0) begin errors++; $display("FAIL clr_seq: got %0d want 0", out_seq); end
    endtask

    task automatic test_reset_mid();
        restart();
        set_wb(1, 1, 32'h1, 32'h0); step();
        set_wb(1, 2, 32'h2, 32'h4); step(); set_wb(0, 0, 0, 0);
        resetn = 0; #1;
        checks++; if ({out_valid, level, halted} !== {1'b0, LW'(0), 1'b0})
            begin errors++; $display("FAIL rst_mid: got v=%b level=%0d halted=%b want 0/0/0", out_valid, level, halted); end
        step(); resetn = 1; step();
        set_wb(1, 6, 32'h66, 32'h0); step(); set_wb(0, 0, 0, 0);
        checks++; if ({out_valid, out_rd, out_seq} !== {1'b1, 5'd6, 16'd0})
            begin errors++; $display("FAIL rst_resume: got v=%b rd=%0d seq=%0d want 1/6/0", out_valid, out_rd, out_seq); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_filter();
        test_overflow();
        test_full_push_pop();
        test_halt();
        test_clear();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
